// File: rtl/drum_pkg.sv
// Shared drum-mesh definitions: node/audio widths, column count and the
// sample-sync state encoding.
package drum_pkg;

  localparam int DRUM_DATA_W  = 18;
  localparam int DRUM_AUDIO_W = 32;
  localparam int DRUM_NCOLS   = 30;

  typedef enum logic [2:0] {
    S_WAIT_COLS,
    S_CAPTURE,
    S_PUSH,
    S_FIRE,
    S_WAIT_DROP
  } sync_state_t;

endpackage

// File: rtl/drum_sample_fmt.sv
// Converts a signed 1.17 node value into a signed audio sample by sign
// extension followed by an arithmetic left shift.
module drum_sample_fmt
  import drum_pkg::*;
#(
  parameter int DATA_W  = DRUM_DATA_W,
  parameter int AUDIO_W = DRUM_AUDIO_W,
  parameter int SHIFT   = 14
) (
  input  logic signed [DATA_W-1:0]  node,
  output logic signed [AUDIO_W-1:0] sample
);

  logic signed [AUDIO_W-1:0] node_ext;

  assign node_ext = {{(AUDIO_W-DATA_W){node[DATA_W-1]}}, node};
  // DATA_W+SHIFT <= AUDIO_W, so the shifted value never overflows.
  assign sample   = node_ext <<< SHIFT;

endmodule

// File: rtl/drum_sample_sync.sv
// Timestep sequencer: waits for all columns, captures the centre node as an
// audio sample, pushes it over valid/ready and then fires the next timestep.
module drum_sample_sync
  import drum_pkg::*;
#(
  parameter int NCOLS   = DRUM_NCOLS,
  parameter int DATA_W  = DRUM_DATA_W,
  parameter int AUDIO_W = DRUM_AUDIO_W,
  parameter int SHIFT   = 14,
  parameter int SETTLE  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NCOLS-1:0]          col_done,
  input  logic signed [DATA_W-1:0]  center_node,
  input  logic                      audio_ready,
  output logic                      audio_valid,
  output logic signed [AUDIO_W-1:0] audio_data,
  output logic                      shoot,
  output logic [31:0]               step_count,
  output logic [31:0]               cycles_per_step,
  output logic                      busy
);

  localparam int SW = $clog2(SETTLE + 1);

  sync_state_t state, state_next;
  logic [SW-1:0] settle_cnt, settle_next;
  logic [31:0] cyc_cnt;
  logic all_done;
  logic signed [AUDIO_W-1:0] fmt_sample;

  drum_sample_fmt #(
    .DATA_W (DATA_W),
    .AUDIO_W(AUDIO_W),
    .SHIFT  (SHIFT)
  ) u_fmt (
    .node  (center_node),
    .sample(fmt_sample)
  );

  assign all_done = &col_done;
  assign busy     = (state != S_WAIT_COLS);

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    case (state)
      S_WAIT_COLS: begin
        // A single low column restarts the settle window; a low enable
        // freezes it without losing progress.
        if (!all_done) begin
          settle_next = '0;
        end else if (enable) begin
          if (settle_cnt == SW'(SETTLE - 1)) state_next = S_CAPTURE;
          if (settle_cnt != SW'(SETTLE)) settle_next = settle_cnt + 1'b1;
        end
      end
      S_CAPTURE: state_next = S_PUSH;
      S_PUSH:    if (audio_ready) state_next = S_FIRE;
      S_FIRE:    state_next = S_WAIT_DROP;
      S_WAIT_DROP: begin
        // Columns must leave their wait state before a new capture can arm.
        if (!all_done) begin
          settle_next = '0;
          state_next  = S_WAIT_COLS;
        end
      end
      default: state_next = S_WAIT_COLS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_WAIT_COLS;
      settle_cnt      <= '0;
      cyc_cnt         <= '0;
      audio_valid     <= 1'b0;
      audio_data      <= '0;
      shoot           <= 1'b0;
      step_count      <= '0;
      cycles_per_step <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      // Shoot is high for exactly the cycle spent in S_FIRE.
      shoot      <= (state == S_PUSH) && audio_ready;

      if (state == S_FIRE) cyc_cnt <= '0;
      else if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;

      case (state)
        S_CAPTURE: begin
          audio_data      <= fmt_sample;
          cycles_per_step <= cyc_cnt;
          audio_valid     <= 1'b1;
        end
        S_PUSH:  if (audio_ready) audio_valid <= 1'b0;
        S_FIRE:  step_count <= step_count + 32'd1;
        default: ;
      endcase
    end
  end

endmodule
